spi_sclkgen: RTL and testbench

- Timing master for the SPI master datapath. It sits directly upstream of the latch/shift stage.
- Divides the system clock into SCLK and drives chip select.
- Issues the one-cycle strobes the shift stage consumes: setup_rst, loadtxdata_en, sclk_en, latchout_en, latchout_dtr_en, latchin_en.
- Frames one transaction per start pulse: CS setup, N SCLK cycles, CS hold, done.

---
 rtl/spi_pkg.sv | 24 ++
 rtl/spi_divtick.sv | 33 +++
 rtl/spi_sclkgen.sv | 238 +++++++++++++++++++++++
 tb/tb_spi_sclkgen.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: FSM encoding, lane modes, default widths.
package spi_pkg;

  localparam int unsigned DEF_DIV_W = 8;
  localparam int unsigned DEF_CNT_W = 8;
  localparam int unsigned DEF_CSW   = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_CSSU = 3'd2,
    ST_RUN  = 3'd3,
    ST_CSHD = 3'd4,
    ST_FIN  = 3'd5
  } sclk_state_e;

  typedef enum logic [1:0] {
    LANE_SINGLE_M0 = 2'd0,
    LANE_SINGLE_M1 = 2'd1,
    LANE_DUAL      = 2'd2,
    LANE_QUAD      = 2'd3
  } lane_mode_e;

endpackage

// File: rtl/spi_divtick.sv
// SCLK half-period divider: down-counter emitting a one-cycle tick every div+1 enabled cycles.
module spi_divtick import spi_pkg::*; #(
  parameter int unsigned DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // Held at the reload value while disabled so the first tick lands div+1 cycles into RUN.
  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (!en) begin
      cnt_d = div;
    end else if (cnt_q == '0) begin
      tick  = 1'b1;
      cnt_d = div;
    end else begin
      cnt_d = cnt_q - DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_sclkgen.sv
// SPI master timing: frames CS, generates SCLK and the shift-stage strobes.
// Optional SPI_SCLKGEN_KEEPCS_EN adds keep_cs to hold CS across transactions.
module spi_sclkgen import spi_pkg::*; #(
  parameter int unsigned DIV_W = DEF_DIV_W,
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned CSW   = DEF_CSW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SPI_SCLKGEN_KEEPCS_EN
  input  logic             keep_cs,
`endif
  input  logic [DIV_W-1:0] clk_div,
  input  logic             cpol,
  input  logic             cpha,
  input  logic             dtr_en,
  input  logic [CNT_W-1:0] num_cycles,
  input  logic [CSW-1:0]   cs_setup,
  input  logic [CSW-1:0]   cs_hold,
  output logic             sclk,
  output logic             ss_n,
  output logic             sclk_en,
  output logic             setup_rst,
  output logic             loadtxdata_en,
  output logic             latchout_en,
  output logic             latchout_dtr_en,
  output logic             latchin_en,
  output logic             busy,
  output logic             done
);

  sclk_state_e state_q, state_d;

  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CSW-1:0]   su_q, su_d, hd_q, hd_d, cnt_q, cnt_d;
  logic [CNT_W:0]   edge_q, edge_d, edge_n;
  logic [CSW:0]     cnt_inc;
  logic cpol_q, cpol_d, cpha_q, cpha_d, dtr_q, dtr_d;
  logic keep_q, keep_d, held_q, held_d, first_q, first_d;
  logic sclk_q, sclk_d, ss_n_q, ss_n_d, sclk_en_q, sclk_en_d;
  logic setup_rst_q, setup_rst_d, loadtx_q, loadtx_d;
  logic busy_q, busy_d, done_q, done_d;
  logic tick, lead, last_edge, leave_run, keep_in;

`ifdef SPI_SCLKGEN_KEEPCS_EN
  assign keep_in = keep_cs;
`else
  assign keep_in = 1'b0;
`endif

  spi_divtick #(.DIV_W(DIV_W)) u_divtick (
    .clk  (clk),
    .rst  (rst),
    .en   (state_q == ST_RUN),
    .div  (div_q),
    .tick (tick)
  );

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    num_d       = num_q;
    su_d        = su_q;
    hd_d        = hd_q;
    cnt_d       = cnt_q;
    edge_d      = edge_q;
    cpol_d      = cpol_q;
    cpha_d      = cpha_q;
    dtr_d       = dtr_q;
    keep_d      = keep_q;
    held_d      = held_q;
    first_d     = first_q;
    sclk_d      = sclk_q;
    ss_n_d      = ss_n_q;
    sclk_en_d   = sclk_en_q;
    setup_rst_d = 1'b0;
    loadtx_d    = 1'b0;
    done_d      = 1'b0;
    latchout_en     = 1'b0;
    latchout_dtr_en = 1'b0;
    latchin_en      = 1'b0;
    leave_run   = 1'b0;
    edge_n      = edge_q + (CNT_W+1)'(1);
    lead        = edge_n[0];
    last_edge   = (edge_n == {num_q, 1'b0});
    cnt_inc     = {1'b0, cnt_q} + (CSW+1)'(1);

    case (state_q)
      ST_IDLE: begin
        sclk_d = cpol;
        if (start && !done_q) begin
          state_d     = ST_LOAD;
          div_d       = clk_div;
          num_d       = num_cycles;
          su_d        = cs_setup;
          hd_d        = cs_hold;
          cpol_d      = cpol;
          cpha_d      = cpha;
          dtr_d       = dtr_en;
          keep_d      = keep_in;
          setup_rst_d = 1'b1;
          loadtx_d    = 1'b1;
        end
      end
      ST_LOAD: begin
        ss_n_d = 1'b0;
        cnt_d  = '0;
        if (held_q) begin
          state_d   = ST_RUN;
          sclk_en_d = 1'b1;
          edge_d    = '0;
          first_d   = 1'b1;
        end else begin
          state_d = ST_CSSU;
        end
      end
      ST_CSSU: begin
        if (cnt_inc >= {1'b0, su_q}) begin
          state_d   = ST_RUN;
          sclk_en_d = 1'b1;
          edge_d    = '0;
          first_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc[CSW-1:0];
        end
      end
      ST_RUN: begin
        first_d = 1'b0;
        if (num_q == '0) begin
          leave_run = 1'b1;
        end else begin
          if (first_q && !cpha_q) latchout_en = 1'b1;
          if (tick) begin
            sclk_d = ~sclk_q;
            edge_d = edge_n;
            // Leading/trailing roles swap with cpha; DTR fills the edge the primary strobe skips.
            if (!cpha_q) begin
              if (lead) begin
                latchin_en      = 1'b1;
                latchout_dtr_en = dtr_q;
              end else begin
                latchin_en = dtr_q;
                if (!last_edge) latchout_en = 1'b1;
              end
            end else begin
              if (lead) begin
                latchout_en = 1'b1;
                latchin_en  = dtr_q;
              end else begin
                latchin_en      = 1'b1;
                latchout_dtr_en = dtr_q;
              end
            end
            leave_run = last_edge;
          end
        end
        if (leave_run) begin
          sclk_en_d = 1'b0;
          cnt_d     = '0;
          state_d   = keep_q ? ST_FIN : ST_CSHD;
        end
      end
      ST_CSHD: begin
        if (cnt_inc >= {1'b0, hd_q}) begin
          ss_n_d  = 1'b1;
          state_d = ST_FIN;
        end else begin
          cnt_d = cnt_inc[CSW-1:0];
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        held_d  = keep_q;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      div_q       <= '0;
      num_q       <= '0;
      su_q        <= '0;
      hd_q        <= '0;
      cnt_q       <= '0;
      edge_q      <= '0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      dtr_q       <= 1'b0;
      keep_q      <= 1'b0;
      held_q      <= 1'b0;
      first_q     <= 1'b0;
      sclk_q      <= 1'b0;
      ss_n_q      <= 1'b1;
      sclk_en_q   <= 1'b0;
      setup_rst_q <= 1'b0;
      loadtx_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      num_q       <= num_d;
      su_q        <= su_d;
      hd_q        <= hd_d;
      cnt_q       <= cnt_d;
      edge_q      <= edge_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      dtr_q       <= dtr_d;
      keep_q      <= keep_d;
      held_q      <= held_d;
      first_q     <= first_d;
      sclk_q      <= sclk_d;
      ss_n_q      <= ss_n_d;
      sclk_en_q   <= sclk_en_d;
      setup_rst_q <= setup_rst_d;
      loadtx_q    <= loadtx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign sclk          = sclk_q;
  assign ss_n          = ss_n_q;
  assign sclk_en       = sclk_en_q;
  assign setup_rst     = setup_rst_q;
  assign loadtxdata_en = loadtx_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_spi_sclkgen.sv
// Self-checking bench for spi_sclkgen against a cycle-timeline reference model.
module tb_spi_sclkgen;

  typedef struct {
    int div;
    int num;
    int su;
    int hd;
    bit cpol;
    bit cpha;
    bit dtr;
    bit keep;
  } cfg_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] clk_div = '0;
  logic       cpol = 1'b0, cpha = 1'b0, dtr_en = 1'b0;
  logic [7:0] num_cycles = '0;
  logic [3:0] cs_setup = '0, cs_hold = '0;
`ifdef SPI_SCLKGEN_KEEPCS_EN
  logic       keep_cs = 1'b0;
`endif
  logic sclk, ss_n, sclk_en, setup_rst, loadtxdata_en;
  logic latchout_en, latchout_dtr_en, latchin_en, busy, done;

  int n_checks = 0;
  int n_fail   = 0;
  bit held     = 1'b0;

  spi_sclkgen #(.DIV_W(8), .CNT_W(8), .CSW(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
`ifdef SPI_SCLKGEN_KEEPCS_EN
    .keep_cs         (keep_cs),
`endif
    .clk_div         (clk_div),
    .cpol            (cpol),
    .cpha            (cpha),
    .dtr_en          (dtr_en),
    .num_cycles      (num_cycles),
    .cs_setup        (cs_setup),
    .cs_hold         (cs_hold),
    .sclk            (sclk),
    .ss_n            (ss_n),
    .sclk_en         (sclk_en),
    .setup_rst       (setup_rst),
    .loadtxdata_en   (loadtxdata_en),
    .latchout_en     (latchout_en),
    .latchout_dtr_en (latchout_dtr_en),
    .latchin_en      (latchin_en),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  // {sclk, ss_n, sclk_en, setup_rst, loadtxdata_en, latchout_en, latchout_dtr_en, latchin_en, busy, done}
  function automatic logic [9:0] obs();
    return {sclk, ss_n, sclk_en, setup_rst, loadtxdata_en,
            latchout_en, latchout_dtr_en, latchin_en, busy, done};
  endfunction

  function automatic int fin_of(cfg_t c, bit h);
    int s, r, hh;
    s  = h ? 0 : ((c.su == 0) ? 1 : c.su);
    r  = (c.num == 0) ? 1 : 2 * c.num * (c.div + 1);
    hh = c.keep ? 0 : ((c.hd == 0) ? 1 : c.hd);
    return 1 + s + r + hh;
  endfunction

  // Expected outputs k cycles after the accepting edge (k=0 is the LOAD cycle).
  function automatic logic [9:0] exp_at(cfg_t c, bit h, int k);
    int p, run0, r, fin, j, e;
    bit s_clk, s_ssn, s_en, s_su, s_ld, s_lo, s_lod, s_li, s_busy, s_done, tk, ld_edge;
    p    = c.div + 1;
    run0 = 1 + (h ? 0 : ((c.su == 0) ? 1 : c.su));
    r    = (c.num == 0) ? 1 : 2 * c.num * p;
    fin  = fin_of(c, h);
    s_clk = c.cpol; s_ssn = 1'b1; s_en = 0; s_su = 0; s_ld = 0;
    s_lo = 0; s_lod = 0; s_li = 0; s_busy = 0; s_done = 0;
    if (k == 0) begin
      s_busy = 1; s_su = 1; s_ld = 1; s_ssn = !h;
    end else if (k < run0) begin
      s_busy = 1; s_ssn = 0;
    end else if (k < run0 + r) begin
      s_busy = 1; s_ssn = 0; s_en = 1;
      if (c.num != 0) begin
        j       = k - run0;
        s_clk   = c.cpol ^ bit'((j / p) % 2);
        tk      = ((j + 1) % p == 0);
        e       = (j + 1) / p;
        ld_edge = (e % 2 == 1);
        if (!c.cpha) begin
          s_lo  = (j == 0) || (tk && !ld_edge && e != 2 * c.num);
          s_li  = tk && (ld_edge || c.dtr);
          s_lod = c.dtr && tk && ld_edge;
        end else begin
          s_lo  = tk && ld_edge;
          s_li  = tk && (!ld_edge || c.dtr);
          s_lod = c.dtr && tk && !ld_edge;
        end
      end
    end else if (k < fin) begin
      s_busy = 1; s_ssn = 0;
    end else if (k == fin) begin
      s_busy = 1; s_ssn = !c.keep;
    end else if (k == fin + 1) begin
      s_done = 1; s_ssn = !c.keep;
    end
    return {s_clk, s_ssn, s_en, s_su, s_ld, s_lo, s_lod, s_li, s_busy, s_done};
  endfunction

  task automatic check(input string tag, input logic [9:0] o, input logic [9:0] e);
    n_checks++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, o, e);
    end
  endtask

  task automatic check_n(input string tag, input int o, input int e);
    n_checks++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, o, e);
    end
  endtask

  task automatic drive_cfg(input cfg_t c);
    clk_div    = 8'(c.div);
    num_cycles = 8'(c.num);
    cs_setup   = 4'(c.su);
    cs_hold    = 4'(c.hd);
    cpol       = c.cpol;
    cpha       = c.cpha;
    dtr_en     = c.dtr;
`ifdef SPI_SCLKGEN_KEEPCS_EN
    keep_cs    = c.keep;
`endif
  endtask

  task automatic scramble_inputs();
    clk_div    = 8'($urandom_range(0, 255));
    num_cycles = 8'($urandom_range(0, 255));
    cs_setup   = 4'($urandom_range(0, 15));
    cs_hold    = 4'($urandom_range(0, 15));
    cpol       = 1'($urandom_range(0, 1));
    cpha       = 1'($urandom_range(0, 1));
    dtr_en     = 1'($urandom_range(0, 1));
`ifdef SPI_SCLKGEN_KEEPCS_EN
    keep_cs    = 1'($urandom_range(0, 1));
`endif
    start      = ($urandom_range(0, 2) == 0);
  endtask

  // One full transaction; with scr=1, inputs and start are disturbed while busy and a
  // start is offered in the done cycle, all of which must be ignored.
  task automatic run_txn(input cfg_t c, input bit scr, input string tag,
                         output int n_lo, output int n_lod, output int n_li,
                         output int n_co, output int n_done);
    int fin;
    logic [9:0] o;
    fin = fin_of(c, held);
    n_lo = 0; n_lod = 0; n_li = 0; n_co = 0; n_done = 0;
    drive_cfg(c);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k <= fin + 1; k++) begin
      o = obs();
      check($sformatf("%s k=%0d", tag, k), o, exp_at(c, held, k));
      n_lo   += int'(o[4]);
      n_lod  += int'(o[3]);
      n_li   += int'(o[2]);
      n_co   += int'(o[4] & o[3]);
      n_done += int'(o[0]);
      if (scr) begin
        if (k < fin) scramble_inputs();
        else if (k == fin) begin drive_cfg(c); start = 1'b0; end
        else start = 1'b1;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    check($sformatf("%s idle", tag), obs(), {c.cpol, !c.keep, 8'b0});
    held = c.keep;
  endtask

  initial begin
    cfg_t c;
    int lo, lod, li, co, dn;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset", obs(), 10'b0100000000);
    rst = 1'b1;
    @(posedge clk); #1;
    check("idle after reset", obs(), 10'b0100000000);

    // Mode 0
    c = '{div: 1, num: 8, su: 0, hd: 0, cpol: 0, cpha: 0, dtr: 0, keep: 0};
    run_txn(c, 1'b0, "mode0", lo, lod, li, co, dn);
    check_n("mode0 latchin count", li, 8);
    check_n("mode0 latchout count", lo, 8);
    check_n("mode0 done count", dn, 1);

    // Mode 3
    c = '{div: 0, num: 4, su: 1, hd: 2, cpol: 1, cpha: 1, dtr: 0, keep: 0};
    run_txn(c, 1'b0, "mode3", lo, lod, li, co, dn);
    check_n("mode3 latchout count", lo, 4);
    check_n("mode3 latchin count", li, 4);
    check_n("mode3 dtr count", lod, 0);

    // DTR
    c = '{div: 1, num: 4, su: 2, hd: 1, cpol: 0, cpha: 0, dtr: 1, keep: 0};
    run_txn(c, 1'b0, "dtr", lo, lod, li, co, dn);
    check_n("dtr latchin count", li, 8);
    check_n("dtr latchout count", lo, 4);
    check_n("dtr latchout_dtr count", lod, 4);
    check_n("dtr coincident", co, 0);

    // num_cycles = 0
    c = '{div: 2, num: 0, su: 0, hd: 0, cpol: 1, cpha: 0, dtr: 1, keep: 0};
    run_txn(c, 1'b0, "num0", lo, lod, li, co, dn);
    check_n("num0 strobes", lo + lod + li, 0);
    check_n("num0 done count", dn, 1);

    // Start while busy / at done, config changes mid-transaction
    c = '{div: 1, num: 3, su: 1, hd: 1, cpol: 0, cpha: 1, dtr: 0, keep: 0};
    run_txn(c, 1'b1, "busy start", lo, lod, li, co, dn);
    check_n("busy start done count", dn, 1);

    // Reset at the third edge
    c = '{div: 1, num: 8, su: 0, hd: 0, cpol: 0, cpha: 0, dtr: 0, keep: 0};
    drive_cfg(c);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k <= 7; k++) begin
      check($sformatf("pre-reset k=%0d", k), obs(), exp_at(c, held, k));
      if (k == 7) rst = 1'b0;
      @(posedge clk); #1;
    end
    check("mid-run reset", obs(), 10'b0100000000);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("post-reset idle %0d", k), obs(), 10'b0100000000);
    end
    held = 1'b0;
    run_txn(c, 1'b0, "after reset", lo, lod, li, co, dn);
    check_n("after reset done count", dn, 1);

`ifdef SPI_SCLKGEN_KEEPCS_EN
    c = '{div: 1, num: 3, su: 2, hd: 2, cpol: 0, cpha: 0, dtr: 0, keep: 1};
    run_txn(c, 1'b0, "keep1", lo, lod, li, co, dn);
    @(posedge clk); #1;
    check("keep gap", obs(), 10'b0000000000);
    c.keep = 1'b0;
    run_txn(c, 1'b0, "keep0", lo, lod, li, co, dn);
    check_n("keep0 done count", dn, 1);
`endif

    // Randomized transactions
    for (int t = 0; t < 24; t++) begin
      c.div  = int'($urandom_range(0, 3));
      c.num  = int'($urandom_range(0, 6));
      c.su   = int'($urandom_range(0, 3));
      c.hd   = int'($urandom_range(0, 3));
      c.cpol = 1'($urandom_range(0, 1));
      c.cpha = 1'($urandom_range(0, 1));
      c.dtr  = 1'($urandom_range(0, 1));
`ifdef SPI_SCLKGEN_KEEPCS_EN
      c.keep = 1'($urandom_range(0, 1));
`else
      c.keep = 1'b0;
`endif
      run_txn(c, 1'b1, $sformatf("rand%0d", t), lo, lod, li, co, dn);
      check_n($sformatf("rand%0d done count", t), dn, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
